// File: rtl/apb_master_arbiter.sv
// rtl/apb_master_arbiter.sv - two-requester round-robin APB master sharing one completer port
// Optional ACCESS-phase timeout is compiled in with APB_ARB_TIMEOUT_EN.
module apb_master_arbiter #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [1:0]              req_valid,
    input  logic [1:0]              req_write,
    input  logic [2*ADDR_WIDTH-1:0] req_addr,
    input  logic [2*DATA_WIDTH-1:0] req_wdata,
    output logic [1:0]              req_done,
    output logic [DATA_WIDTH-1:0]   rsp_rdata,
    output logic                    rsp_err,
    output logic                    psel,
    output logic                    penable,
    output logic                    pwrite,
    output logic [ADDR_WIDTH-1:0]   paddr,
    output logic [DATA_WIDTH-1:0]   pwdata,
    input  logic [DATA_WIDTH-1:0]   prdata,
    input  logic                    pready,
    input  logic                    pslverr
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic                    grant_q, grant_d;
    logic                    last_grant_q, last_grant_d;
    logic                    pwrite_q, pwrite_d;
    logic [ADDR_WIDTH-1:0]   paddr_q, paddr_d;
    logic [DATA_WIDTH-1:0]   pwdata_q, pwdata_d;
    logic [1:0]              done_q, done_d;
    logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
    logic                    err_q, err_d;

    logic [1:0]              eligible;
    logic                    pick;
    logic                    tmo_hit;

    // A requester whose done is still showing is masked so its finished command is not re-granted.
    assign eligible = req_valid & ~done_q;
    assign pick     = (&eligible) ? ~last_grant_q : eligible[1];

`ifdef APB_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] tmo_q, tmo_d;

    assign tmo_hit = (tmo_q == CW'(TIMEOUT_CYCLES - 1));
`else
    logic unused_timeout_cfg;

    assign tmo_hit            = 1'b0;
    assign unused_timeout_cfg = (TIMEOUT_CYCLES == 0);
`endif

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        pwrite_d     = pwrite_q;
        paddr_d      = paddr_q;
        pwdata_d     = pwdata_q;
        done_d       = 2'b00;
        rdata_d      = rdata_q;
        err_d        = err_q;
`ifdef APB_ARB_TIMEOUT_EN
        tmo_d        = tmo_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (|eligible) begin
                    grant_d  = pick;
                    pwrite_d = req_write[pick];
                    paddr_d  = pick ? req_addr[2*ADDR_WIDTH-1:ADDR_WIDTH] : req_addr[ADDR_WIDTH-1:0];
                    if (req_write[pick]) begin
                        pwdata_d = pick ? req_wdata[2*DATA_WIDTH-1:DATA_WIDTH] : req_wdata[DATA_WIDTH-1:0];
                    end else begin
                        pwdata_d = '0;
                    end
                    state_d  = ST_SETUP;
                end
            end
            ST_SETUP: begin
                state_d = ST_ACCESS;
`ifdef APB_ARB_TIMEOUT_EN
                tmo_d   = '0;
`endif
            end
            ST_ACCESS: begin
                if (pready || tmo_hit) begin
                    state_d      = ST_IDLE;
                    done_d       = grant_q ? 2'b10 : 2'b01;
                    last_grant_d = grant_q;
                    err_d        = pready ? pslverr : 1'b1;
                    rdata_d      = (pready && !pwrite_q) ? prdata : '0;
                end
`ifdef APB_ARB_TIMEOUT_EN
                else begin
                    tmo_d = tmo_q + CW'(1);
                end
`endif
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            grant_q      <= 1'b0;
            last_grant_q <= 1'b1;
            pwrite_q     <= 1'b0;
            paddr_q      <= '0;
            pwdata_q     <= '0;
            done_q       <= 2'b00;
            rdata_q      <= '0;
            err_q        <= 1'b0;
`ifdef APB_ARB_TIMEOUT_EN
            tmo_q        <= '0;
`endif
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            pwrite_q     <= pwrite_d;
            paddr_q      <= paddr_d;
            pwdata_q     <= pwdata_d;
            done_q       <= done_d;
            rdata_q      <= rdata_d;
            err_q        <= err_d;
`ifdef APB_ARB_TIMEOUT_EN
            tmo_q        <= tmo_d;
`endif
        end
    end

    assign psel      = (state_q != ST_IDLE);
    assign penable   = (state_q == ST_ACCESS);
    assign pwrite    = pwrite_q;
    assign paddr     = paddr_q;
    assign pwdata    = pwdata_q;
    assign req_done  = done_q;
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;

endmodule

// File: doc/apb_master_arbiter.md
# apb_master_arbiter

Two-requester APB master that shares a single APB completer port (such as the peripheral register slave at base 0x4000_1xxx) between two on-chip requesters. It arbitrates round-robin and sequences each granted command through the APB IDLE→SETUP→ACCESS protocol, honouring pready wait states. It returns read data and error status to the winning requester with a one-cycle done pulse.

## Interface
- ADDR_WIDTH, 32, APB address width
- DATA_WIDTH, 32, APB data width
- TIMEOUT_CYCLES, 16, maximum ACCESS-phase cycles with pready low; used only when the timeout feature is compiled in
- clk  input  1  system clock; all logic is on the rising edge
- rst  input  1  synchronous, active-high reset
- req_valid  input  2  per-requester command request; bit i belongs to requester i
- req_write  input  2  per-requester direction: 1 = write, 0 = read
- req_addr  input  2*ADDR_WIDTH  per-requester address; requester i uses slice [i*ADDR_WIDTH +: ADDR_WIDTH]
- req_wdata  input  2*DATA_WIDTH  per-requester write data, sliced the same way
- req_done  output  2  one-cycle completion pulse to the granted requester
- rsp_rdata  output  DATA_WIDTH  read data of the last completed transfer
- rsp_err  output  1  error flag of the last completed transfer
- psel, penable, pwrite  output  1 each  APB master controls
- paddr  output  ADDR_WIDTH  APB address
- pwdata  output  DATA_WIDTH  APB write data
- prdata  input  DATA_WIDTH  APB read data
- pready  input  1  APB ready
- pslverr  input  1  APB error

## Operation
- FSM states:
  - IDLE: psel=0, penable=0.
  - SETUP: psel=1, penable=0.
  - ACCESS: psel=1, penable=1.
- IDLE, with any eligible req_valid bit set:
  - Grant one requester.
  - Latch its write, addr and wdata into pwrite, paddr and pwdata. pwdata is 0 for reads.
  - Go to SETUP.
- SETUP → ACCESS unconditionally.
- ACCESS, pready=0: stay in ACCESS. All APB outputs hold stable.
- ACCESS, pready=1:
  - Capture pslverr into rsp_err.
  - Capture prdata into rsp_rdata on reads; load 0 on writes.
  - Go to IDLE. req_done[grant] is 1 in the following cycle.
- Eligibility: a requester whose req_done bit is currently 1 is masked in that IDLE cycle. This prevents a stale re-grant of the same command.
- Round-robin arbitration:
  - A last_grant register gives priority to the requester that was not granted last.
  - last_grant resets to 1, so requester 0 wins the first contention.
  - last_grant updates only when a transfer completes.
  - If only one requester is eligible, it wins regardless of priority.
- Requester rules:
  - Hold req_valid and the command stable until req_done.
  - The command is sampled only in the grant cycle.
  - Deasserting req_valid after grant does not abort the transfer; done is still issued.
- rsp_rdata and rsp_err hold their values until the next completion.

## Timing
- Reset values: psel=0, penable=0, pwrite=0, paddr=0, pwdata=0, req_done=0, rsp_rdata=0, rsp_err=0, state=IDLE, last_grant=1.
- Minimum transfer cycle count, with pready=1 in the first ACCESS cycle:
  - Grant edge → SETUP (1 cycle) → ACCESS (1 cycle) → IDLE with req_done=1.
  - Total: 3 cycles from a request seen in IDLE to done.
- Each pready-low cycle adds exactly one ACCESS cycle.
- Back-to-back transfers: IDLE lasts at least one cycle. A new grant may occur in the same cycle req_done is high, for the other requester only.
- Simultaneous requests alternate strictly. With both requesters held continuously valid, the grants run 0,1,0,1,…, one transfer per 3 cycles.
- pready and pslverr are ignored outside ACCESS.
- Reset asserted mid-transfer: the transfer is abandoned, all outputs go to their reset values on the next edge, and no req_done is issued.

## Configuration
- APB_ARB_TIMEOUT_EN defined:
  - A counter runs during ACCESS.
  - If pready is still 0 after TIMEOUT_CYCLES ACCESS cycles, the FSM goes to IDLE.
  - req_done[grant] is issued with rsp_err=1 and rsp_rdata=0, and last_grant updates.
  - The counter clears on entry to ACCESS.
- APB_ARB_TIMEOUT_EN undefined: no counter; ACCESS waits indefinitely for pready, and TIMEOUT_CYCLES is unused.

## Test plan
- Single write, zero wait: req_valid=01, write, addr 0x4000_1004, wdata 0xDEADBEEF, pready=1.
  - Expect psel high for 2 cycles, penable in cycle 2, paddr and pwdata as given.
  - Expect req_done=01 on cycle 3 with rsp_err=0 and rsp_rdata=0.
- Read with 2 wait states: requester 1 reads 0x4000_1008, pready low for 2 ACCESS cycles, then prdata=0x12345678.
  - Expect ACCESS to last 3 cycles.
  - Expect req_done=10 and rsp_rdata=0x12345678.
- Contention: req_valid=11 held continuously.
  - Expect grant order 0,1,0,1.
  - Expect a req_done pulse every 3 cycles, alternating bits.
- Slave error: pslverr=1 with pready=1 on a read.
  - Expect rsp_err=1.
  - Expect the next completion with pslverr=0 to clear rsp_err.
- Reset mid-ACCESS: assert rst while pready is held low.
  - Expect psel=0, penable=0 and all outputs at 0 on the next edge, with no req_done.
- APB_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=4, pready stuck at 0.
  - Expect ACCESS to last exactly 4 cycles.
  - Expect req_done with rsp_err=1 and rsp_rdata=0.
